// File: rtl/serial_add_ctrl_pkg.sv
// Shared types and helpers for the bit-serial adder sequencer.
// Holds the FSM state encoding and the legal operand-width range.
package serial_add_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    localparam int unsigned WMin = 1;
    localparam int unsigned WMax = 64;

    function automatic bit w_legal(input int unsigned w);
        return (w >= WMin) && (w <= WMax);
    endfunction

endpackage

// File: rtl/serial_add_ctrl_fulladd.sv
// Single-bit full adder; the one arithmetic cell the sequencer time-shares.
module serial_add_ctrl_fulladd (
    input  logic x,
    input  logic y,
    input  logic z,
    output logic s,
    output logic co
);

    assign s  = x ^ y ^ z;
    assign co = (x & y) | (z & (x ^ y));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: {cout,sum} = a + b + cin, one bit per clock, LSB first,
// driven by a start/busy/done handshake around a single full-adder cell.
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] sum,
    output logic         cout
);

    localparam int unsigned CW = $clog2(W + 1);

    if (!w_legal(W)) begin : g_bad_w
        $error("serial_add_ctrl: W must be in 1..64");
    end

    state_e         state_q, state_d;
    logic [W-1:0]   a_sh_q, b_sh_q, res_sh_q, res_nxt;
    logic           c_q;
    logic [CW-1:0]  cnt_q;
    logic           busy_q, done_q, cout_q;
    logic [W-1:0]   sum_q;
    logic           fa_sum, fa_cout;
    logic           accept, last;

    serial_add_ctrl_fulladd u_fa (
        .x  (a_sh_q[0]),
        .y  (b_sh_q[0]),
        .z  (c_q),
        .s  (fa_sum),
        .co (fa_cout)
    );

    // New sum bit enters at the MSB so the LSB-first result lands aligned after W shifts.
    if (W == 1) begin : g_w1
        assign res_nxt = fa_sum;
    end else begin : g_wn
        assign res_nxt = {fa_sum, res_sh_q[W-1:1]};
    end

    assign last = (cnt_q == CW'(W - 1));

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                    accept  = 1'b1;
                end
            end
            StRun: begin
                if (last) state_d = StDone;
            end
            StDone: begin
                if (start) begin
                    state_d = StRun;
                    accept  = 1'b1;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            c_q      <= 1'b0;
            cnt_q    <= '0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d == StRun);
            done_q  <= (state_d == StDone);
            if (accept) begin
                a_sh_q   <= a;
                b_sh_q   <= b;
                c_q      <= cin;
                res_sh_q <= '0;
                cnt_q    <= '0;
            end else if (state_q == StRun) begin
                a_sh_q   <= a_sh_q >> 1;
                b_sh_q   <= b_sh_q >> 1;
                c_q      <= fa_cout;
                res_sh_q <= res_nxt;
                cnt_q    <= cnt_q + CW'(1);
                if (last) begin
                    sum_q  <= res_nxt;
                    cout_q <= fa_cout;
                end
            end
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule
